// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator JK floor driver.
// JK drive codes are packed as {j,k}; the toggle code 2'b11 is deliberately absent.
package elev_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_STEP,
    S_SETTLE,
    S_DOOR,
    S_FAULT
  } state_t;

  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_RESET = 2'b01;
  localparam logic [1:0] JK_SET   = 2'b10;

  localparam int DEF_FLOORS      = 8;
  localparam int DEF_FLOOR_W     = 3;
  localparam int DEF_MOVE_CYCLES = 3;
  localparam int DEF_DOOR_CYCLES = 4;

  // One bit of the floor register: drive it from cur towards tgt without toggling.
  function automatic logic [1:0] jk_code(input logic cur, input logic tgt);
    if (tgt && !cur) return JK_SET;
    else if (!tgt && cur) return JK_RESET;
    else return JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation: per bit, the set/reset/hold code that moves
// the external JK bank from its current value to the target value.
module jk_excite
  import elev_pkg::*;
#(
  parameter int W = DEF_FLOOR_W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] target,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {j[i], k[i]} = jk_code(cur[i], target[i]);
  end

endmodule

// File: rtl/elev_jk_floor_driver.sv
// Elevator car controller: latches calls, runs SCAN, times travel and door dwell,
// and steps an external JK floor register by one floor per ff_enable pulse.
// Optional macro ELEV_READBACK_CHECK_EN enables the settle readback and range check (err/FAULT).
module elev_jk_floor_driver
  import elev_pkg::*;
#(
  parameter int FLOORS      = DEF_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_req,
  input  logic [FLOOR_W-1:0] floor_q,
  output logic [FLOOR_W-1:0] jk_j,
  output logic [FLOOR_W-1:0] jk_k,
  output logic               ff_enable,
  output logic               door_open,
  output logic               moving,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending,
  output logic               err
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FLOOR_W-1:0] target;

  logic [FLOORS-1:0]  eff, cur_onehot, above_m, below_m, clear_mask;
  logic               cur_hit, any_above, any_below, ahead, behind;
  logic               eval_dir, cur_call, settle_ok, range_bad, do_eval, go_fault;
  state_t             eval_next;
  logic [FLOOR_W-1:0] eval_target, step_j, step_k;

  jk_excite #(.W(FLOOR_W)) u_excite (
    .cur    (floor_q),
    .target (target),
    .j      (step_j),
    .k      (step_k)
  );

  // Evaluation sees this cycle's call pulses so a call at the current floor opens the door next cycle.
  always_comb begin
    above_m = '0;
    below_m = '0;
    for (int i = 0; i < FLOORS; i++) begin
      above_m[i] = (i > int'(floor_q));
      below_m[i] = (i < int'(floor_q));
    end
    cur_onehot = {{(FLOORS-1){1'b0}}, 1'b1} << floor_q;
    eff        = pending | call_req;
    cur_hit    = |(eff & cur_onehot);
    any_above  = |(eff & above_m);
    any_below  = |(eff & below_m);
    ahead      = dir_up ? any_above : any_below;
    behind     = dir_up ? any_below : any_above;
    eval_dir   = dir_up;
    eval_next  = S_IDLE;
    if (cur_hit) begin
      eval_next = S_DOOR;
    end else if (ahead) begin
      eval_next = S_MOVE;
    end else if (behind) begin
      eval_next = S_MOVE;
      eval_dir  = ~dir_up;
    end
    eval_target = eval_dir ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    cur_call    = |(call_req & cur_onehot);
`ifdef ELEV_READBACK_CHECK_EN
    settle_ok = (floor_q == target);
    range_bad = (int'(floor_q) >= FLOORS);
`else
    settle_ok = 1'b1;
    range_bad = 1'b0;
`endif
    go_fault = range_bad || ((state == S_SETTLE) && !settle_ok);
    do_eval  = (state == S_IDLE) || ((state == S_SETTLE) && settle_ok) ||
               ((state == S_DOOR) && (cnt == CNT_W'(DOOR_CYCLES - 1)) && !cur_call);
    clear_mask = ((state == S_DOOR) || (do_eval && (eval_next == S_DOOR) && !go_fault))
               ? cur_onehot : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending | call_req) & ~clear_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      target    <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      ff_enable <= 1'b0;
      door_open <= 1'b0;
      moving    <= 1'b0;
      dir_up    <= 1'b1;
      err       <= 1'b0;
    end else if (go_fault) begin
      state     <= S_FAULT;
      err       <= 1'b1;
      cnt       <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      ff_enable <= 1'b0;
      door_open <= 1'b0;
      moving    <= 1'b0;
    end else if (do_eval) begin
      state     <= eval_next;
      dir_up    <= eval_dir;
      cnt       <= '0;
      moving    <= (eval_next == S_MOVE);
      door_open <= (eval_next == S_DOOR);
      if (eval_next == S_MOVE) target <= eval_target;
    end else begin
      case (state)
        S_MOVE: begin
          if (cnt == CNT_W'(MOVE_CYCLES - 1)) begin
            state     <= S_STEP;
            cnt       <= '0;
            ff_enable <= 1'b1;
            jk_j      <= step_j;
            jk_k      <= step_k;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STEP: begin
          state     <= S_SETTLE;
          ff_enable <= 1'b0;
          jk_j      <= '0;
          jk_k      <= '0;
        end
        // A repeated call for the current floor holds the door for a fresh dwell.
        S_DOOR: begin
          if (cur_call) cnt <= '0;
          else          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elev_jk_floor_driver.sv
// Bench for elev_jk_floor_driver: JK bank model plus a floor-level SCAN planner
// that predicts step and door events (edge index, floor, J/K codes).
module tb_elev_jk_floor_driver;

  localparam int FLOORS = 8;
  localparam int FW     = 3;
  localparam int MC     = 3;
  localparam int DC     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [FLOORS-1:0] call_req = '0;
  logic [FW-1:0]     floor_q;
  logic [FW-1:0]     jk_j, jk_k;
  logic              ff_enable, door_open, moving, dir_up, err;
  logic [FLOORS-1:0] pending;

  logic [FW-1:0] bank;
  logic          freeze = 1'b0;

  int checks = 0;
  int passed = 0;

  // planner state and expected event queues
  int          m_floor = 0;
  bit          m_dir = 1'b1;
  int          m_end_t;
  int          exp_door_t[$];
  logic [FW-1:0] exp_q[$];
  int          exp_step_t[$];
  logic [FW-1:0] exp_step_from[$];
  logic [FW-1:0] exp_step_to[$];

  elev_jk_floor_driver #(
    .FLOORS(FLOORS), .FLOOR_W(FW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .floor_q(floor_q),
    .jk_j(jk_j), .jk_k(jk_k), .ff_enable(ff_enable), .door_open(door_open),
    .moving(moving), .dir_up(dir_up), .pending(pending), .err(err)
  );

  // clock / reset-shared JK bank
  always #5 clk = ~clk;

  assign floor_q = bank;

  always @(posedge clk or posedge reset) begin
    if (reset) bank <= '0;
    else if (ff_enable && !freeze) begin
      for (int i = 0; i < FW; i++) begin
        case ({jk_j[i], jk_k[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
      end
    end
  end

  // SCAN planner with a static call set: time advances in whole floors and dwells.
  task automatic model_plan(input logic [FLOORS-1:0] p_in);
    logic [FLOORS-1:0] p;
    int f, t;
    bit d, above, below, ahead, behind;
    p = p_in; f = m_floor; d = m_dir; t = 0;
    for (int guard = 0; guard < 64; guard++) begin
      if (p[f]) begin
        exp_door_t.push_back(t);
        exp_q.push_back(FW'(f));
        p[f] = 1'b0;
        t += DC;
      end else begin
        above = 1'b0; below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
          if (p[i] && i > f) above = 1'b1;
          if (p[i] && i < f) below = 1'b1;
        end
        ahead  = d ? above : below;
        behind = d ? below : above;
        if (!ahead && !behind) break;
        if (!ahead) d = !d;
        exp_step_t.push_back(t + MC);
        exp_step_from.push_back(FW'(f));
        f = d ? f + 1 : f - 1;
        exp_step_to.push_back(FW'(f));
        t += MC + 2;
      end
    end
    m_end_t = t; m_floor = f; m_dir = d;
  endtask

  task automatic run_scenario(input logic [FLOORS-1:0] p, input string name);
    int k, et, bad_jk, left;
    bit prev_door;
    logic [FW-1:0] fr, to, ej, ek, ef;
    model_plan(p);
    @(negedge clk); call_req = p;
    @(posedge clk); k = 0;
    @(negedge clk); call_req = '0;
    prev_door = 1'b0; bad_jk = 0;
    while (k <= m_end_t + 1) begin
      if (ff_enable) begin
        checks++;
        if (exp_step_t.size() == 0) begin
          $display("FAIL %s unexpected_step: edge %0d j=%b k=%b, no step expected", name, k, jk_j, jk_k);
        end else begin
          et = exp_step_t.pop_front(); fr = exp_step_from.pop_front(); to = exp_step_to.pop_front();
          ej = to & ~fr; ek = fr & ~to;
          if (et !== k || jk_j !== ej || jk_k !== ek)
            $display("FAIL %s step: edge %0d j=%b k=%b, expected edge %0d j=%b k=%b", name, k, jk_j, jk_k, et, ej, ek);
          else passed++;
        end
      end else if ((jk_j | jk_k) != '0) bad_jk++;
      if (door_open && !prev_door) begin
        checks++;
        if (exp_door_t.size() == 0) begin
          $display("FAIL %s unexpected_door: edge %0d floor %0d", name, k, floor_q);
        end else begin
          et = exp_door_t.pop_front(); ef = exp_q.pop_front();
          if (et !== k || floor_q !== ef)
            $display("FAIL %s door: edge %0d floor %0d, expected edge %0d floor %0d", name, k, floor_q, et, ef);
          else passed++;
        end
      end
      prev_door = door_open;
      @(posedge clk); k++;
      @(negedge clk);
    end
    left = exp_step_t.size() + exp_door_t.size();
    checks++;
    if (left !== 0) $display("FAIL %s missing_events: %0d left, expected 0", name, left);
    else passed++;
    checks++;
    if (bad_jk !== 0) $display("FAIL %s jk_outside_step: %0d cycles, expected 0", name, bad_jk);
    else passed++;
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0 || pending !== '0 || err !== 1'b0)
      $display("FAIL %s idle_state: moving=%b door=%b pending=%h err=%b, expected 0 0 00 0", name, moving, door_open, pending, err);
    else passed++;
    checks++;
    if (dir_up !== m_dir || floor_q !== FW'(m_floor))
      $display("FAIL %s position: dir_up=%b floor=%0d, expected %b %0d", name, dir_up, floor_q, m_dir, m_floor);
    else passed++;
    exp_door_t.delete(); exp_q.delete();
    exp_step_t.delete(); exp_step_from.delete(); exp_step_to.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (jk_j !== '0 || jk_k !== '0 || ff_enable !== 1'b0 || door_open !== 1'b0)
      $display("FAIL reset_drives: j=%b k=%b en=%b door=%b, expected all 0", jk_j, jk_k, ff_enable, door_open);
    else passed++;
    checks++;
    if (moving !== 1'b0 || dir_up !== 1'b1 || pending !== '0 || err !== 1'b0)
      $display("FAIL reset_state: moving=%b dir_up=%b pending=%h err=%b, expected 0 1 00 0", moving, dir_up, pending, err);
    else passed++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (floor_q !== '0 || moving !== 1'b0 || ff_enable !== 1'b0)
      $display("FAIL reset_idle: floor=%0d moving=%b en=%b, expected 0 0 0", floor_q, moving, ff_enable);
    else passed++;
  endtask

  task automatic test_multi_floor();
    run_scenario(8'h08, "multi_floor");
  endtask

  task automatic test_scan_reversal();
    run_scenario(8'h22, "scan_reversal");
  endtask

  task automatic test_far_end();
    run_scenario(8'h80, "to_top");
    run_scenario(8'h04, "top_reverse");
  endtask

  task automatic test_idle_door();
    run_scenario(8'h04, "idle_door");
  endtask

  task automatic test_door_restart();
    logic [FLOORS-1:0] oh;
    int high;
    oh = {{(FLOORS-1){1'b0}}, 1'b1} << m_floor;
    @(negedge clk); call_req = oh;
    @(posedge clk);
    @(negedge clk); call_req = '0;
    high = 0;
    for (int k = 0; k <= 12; k++) begin
      if (door_open) high++;
      if (k == 2) call_req = oh;
      if (k == 3) begin
        call_req = '0;
        checks++;
        if (pending !== '0) $display("FAIL door_call_latched: pending=%h, expected 00", pending);
        else passed++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (high !== DC + 3) $display("FAIL door_restart_len: %0d cycles open, expected %0d", high, DC + 3);
    else passed++;
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0 || ff_enable !== 1'b0)
      $display("FAIL door_restart_end: door=%b moving=%b en=%b, expected 0 0 0", door_open, moving, ff_enable);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_scenario(FLOORS'($urandom_range(1, (1 << FLOORS) - 1)), "random");
  endtask

  task automatic test_reset_mid_step();
    logic [FLOORS-1:0] p;
    bit seen;
    p = (m_floor == 0) ? 8'h80 : 8'h01;
    @(negedge clk); call_req = p;
    @(negedge clk); call_req = '0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ff_enable) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) $display("FAIL mid_step_wait: no ff_enable within 20 cycles, expected one");
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if (ff_enable !== 1'b0 || jk_j !== '0 || jk_k !== '0)
      $display("FAIL mid_step_drop: en=%b j=%b k=%b, expected 0 000 000", ff_enable, jk_j, jk_k);
    else passed++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== '0 || dir_up !== 1'b1 || floor_q !== '0 || moving !== 1'b0)
      $display("FAIL mid_step_after: pending=%h dir_up=%b floor=%0d moving=%b, expected 00 1 0 0", pending, dir_up, floor_q, moving);
    else passed++;
    m_floor = 0; m_dir = 1'b1;
  endtask

  task automatic test_readback_fault();
    int ff_cnt, ff_late, err_seen;
    freeze = 1'b1;
    @(negedge clk); call_req = 8'h02;
    @(posedge clk);
    @(negedge clk); call_req = '0;
    ff_cnt = 0; ff_late = 0; err_seen = 0;
    for (int k = 0; k <= 20; k++) begin
      if (ff_enable) ff_cnt++;
      if (ff_enable && k >= MC + 2) ff_late++;
      if (err) err_seen++;
`ifdef ELEV_READBACK_CHECK_EN
      if (k == MC + 1) begin
        checks++;
        if (err !== 1'b0) $display("FAIL fault_early: err=%b during settle, expected 0", err);
        else passed++;
      end
      if (k == MC + 2) begin
        checks++;
        if (err !== 1'b1 || moving !== 1'b0)
          $display("FAIL fault_entry: err=%b moving=%b, expected 1 0", err, moving);
        else passed++;
      end
`endif
      @(posedge clk);
      @(negedge clk);
    end
`ifdef ELEV_READBACK_CHECK_EN
    checks++;
    if (ff_late !== 0 || err !== 1'b1 || pending !== 8'h02 || door_open !== 1'b0)
      $display("FAIL fault_hold: late_en=%0d err=%b pending=%h door=%b, expected 0 1 02 0", ff_late, err, pending, door_open);
    else passed++;
`else
    checks++;
    if (err_seen !== 0 || ff_cnt !== 4)
      $display("FAIL no_check_err: err_cycles=%0d steps=%0d, expected 0 4", err_seen, ff_cnt);
    else passed++;
`endif
    freeze = 1'b0;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || moving !== 1'b0 || floor_q !== '0)
      $display("FAIL fault_reset: err=%b moving=%b floor=%0d, expected 0 0 0", err, moving, floor_q);
    else passed++;
    m_floor = 0; m_dir = 1'b1;
  endtask

  initial begin
    test_reset();
    test_multi_floor();
    test_scan_reversal();
    test_far_end();
    test_idle_door();
    test_door_restart();
    test_random();
    test_reset_mid_step();
    test_readback_fault();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/elev_jk_floor_driver.md
Name: elev_jk_floor_driver

Overview:
Elevator car controller that drives the J/K/enable inputs of an external bank of JK flip-flops holding the current floor number, and reads their q outputs back.
It latches hall/car calls, runs a SCAN direction policy, times travel and door dwell, and issues one-cycle JK excitations to step the floor register by ±1.
It sits between the call buttons and the floor-state JK bank, alongside the display logic.

Parameters:
FLOORS, 8, number of floors (2..16)
FLOOR_W, 3, width of floor number (must be ≥ clog2(FLOORS))
MOVE_CYCLES, 3, clock cycles of travel before each floor step (≥1)
DOOR_CYCLES, 4, clock cycles door_open stays asserted (≥1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state (the JK bank shares this reset)
call_req  in  FLOORS  per-floor call pulses, OR-ed into pending register each cycle
floor_q  in  FLOOR_W  q outputs of external JK bank (current floor)
jk_j  out  FLOOR_W  per-bit J drive
jk_k  out  FLOOR_W  per-bit K drive
ff_enable  out  1  enable to JK bank, high exactly one cycle per step
door_open  out  1  door open indicator
moving  out  1  high in MOVE/STEP/SETTLE
dir_up  out  1  current direction, 1 = up
pending  out  FLOORS  latched outstanding calls
err  out  1  sticky readback/range error

Behaviour:
- Reset values: jk_j=0, jk_k=0, ff_enable=0, door_open=0, moving=0, dir_up=1, pending=0, err=0, state IDLE, counters 0.
- States: IDLE, MOVE, STEP, SETTLE, DOOR, FAULT.
- pending <= (pending | call_req) & ~clear_mask; clear_mask = bit floor_q on DOOR entry and throughout DOOR (a call for the current floor during DOOR is not latched and restarts the door counter).
- Evaluation (IDLE, SETTLE end, DOOR end): if pending[floor_q] -> DOOR; else if calls beyond floor_q in dir_up direction -> MOVE; else if calls in opposite direction -> flip dir_up, MOVE; else IDLE.
- MOVE: counts MOVE_CYCLES cycles, then STEP. target = floor_q+1 (up) or floor_q-1 (down), registered on MOVE entry.
- STEP: exactly one cycle; ff_enable=1; per bit i: target[i]=1 & floor_q[i]=0 -> J=1,K=0; target[i]=0 & floor_q[i]=1 -> J=0,K=1; equal -> J=0,K=0. Toggle code 11 is never driven. Outside STEP, jk_j=jk_k=0.
- SETTLE: one cycle; compares floor_q to target. Mismatch -> err=1, FAULT. Match -> evaluation.
- Floor period = MOVE_CYCLES+2 cycles. IDLE call at current floor -> door_open on next cycle.
- DOOR: door_open=1 for DOOR_CYCLES cycles, then evaluation.
- Boundaries: never steps above FLOORS-1 or below 0. At an end floor with no calls beyond it, direction reverses. floor_q ≥ FLOORS in any state -> err=1, FAULT.
- FAULT: all drives 0, calls still latched; exits only by reset.
- Reset mid-operation: outputs clear immediately (async); JK bank returns to floor 0.

Optional Feature:
ELEV_READBACK_CHECK_EN. When defined: SETTLE compare and range check active; err and FAULT reachable.
When undefined: SETTLE always passes, err tied 0, FAULT unreachable. Timing is identical either way.

Decomposition:
- Package elev_pkg: state enum; JK code constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10; default FLOORS/FLOOR_W.
- One sub-module jk_excite: combinational per-bit (current, target) -> (j,k).
- The FSM, counters and pending register stay in the top.

Test Plan:
- Reset, JK bank model at floor 0, call_req=8'h08 -> steps 0→1 (j=001,k=000), 1→2 (j=010,k=001), 2→3 (j=001,k=000), 5 cycles apart. Then door_open 4 cycles; pending[3] cleared.
- IDLE at floor 2, call_req=8'h04 -> door_open next cycle for 4 cycles; ff_enable never high.
- At floor 3 going up, pending=8'h22 -> serves floor 5 first, then reverses and serves floor 1; dir_up=0 after reversal.
- At floor 7 with only pending[2] -> dir_up flips to 0 without any step attempt upward; arrives at floor 2 after 25 cycles plus dwell.
- Bench JK model ignores enable (floor_q frozen) with ELEV_READBACK_CHECK_EN defined -> err=1 at end of SETTLE, FAULT, no further ff_enable; without the macro err stays 0.
- Assert reset during STEP -> ff_enable, jk_j, jk_k drop the same cycle; pending=0, dir_up=1 after release.
